// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared encodings for the pipeline hazard sequencer.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_BOOT     = 2'b00;
    localparam logic [1:0] ST_RUN      = 2'b01;
    localparam logic [1:0] ST_MEM_WAIT = 2'b10;
    localparam logic [1:0] ST_HALT     = 2'b11;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// Hazard flags from ID/EX/MEM and the enable/flush strobes back to the pipeline.
interface pipeline_hazard_sequencer_if;

    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_uses_rs1;
    logic       id_uses_rs2;
    logic       ex_is_load;
    logic [4:0] ex_rd;
    logic       ex_redirect;
    logic       mem_access;
    logic       dmem_ack;
    logic       dmem_req;
    logic       pc_en;
    logic       if_id_en;
    logic       if_id_flush;
    logic       id_ex_en;
    logic       id_ex_flush;
    logic       ex_mem_en;
    logic       mem_wb_en;

    // Pipeline datapath side: supplies hazard flags, obeys the strobes.
    modport master (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd,
               ex_redirect, mem_access, dmem_ack,
        input  dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en
    );

    // Sequencer side.
    modport slave (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_load, ex_rd,
               ex_redirect, mem_access, dmem_ack,
        output dmem_req, pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
               ex_mem_en, mem_wb_en
    );

endinterface

// File: rtl/pipeline_hazard_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, hold at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != '1))
            cnt <= cnt + W'(1);
    end

endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// Stage-2 pipeline sequencer: load-use stalls, redirect flushes, dmem hold.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// BOOT     | first cycle after reset: flush IF/ID and ID/EX, nothing moves
// RUN      | normal issue; resolves redirect / load-use / memory entry
// MEM_WAIT | dmem access outstanding, whole pipeline frozen
// HALT     | dmem never answered; frozen until reset
module pipeline_hazard_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    pipeline_hazard_sequencer_if.slave    bus,
    output logic                          mem_fault,
    output logic [CNT_W-1:0]              stall_cnt,
    output logic [CNT_W-1:0]              flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    logic [1:0]        state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_clr, wait_inc;
    logic              stall_inc, flush_inc;
    logic              load_use;
    logic              en_all;

    assign load_use = bus.ex_is_load && (bus.ex_rd != REG_X0) &&
                      ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

    assign mem_fault = (state == ST_HALT);

    // Next state and combinational strobes from current state and hazard flags.
    always_comb begin
        state_nxt       = state;
        en_all          = 1'b0;
        bus.pc_en       = 1'b0;
        bus.if_id_en    = 1'b0;
        bus.id_ex_en    = 1'b0;
        bus.ex_mem_en   = 1'b0;
        bus.mem_wb_en   = 1'b0;
        bus.if_id_flush = 1'b0;
        bus.id_ex_flush = 1'b0;
        bus.dmem_req    = 1'b0;
        wait_clr        = 1'b0;
        wait_inc        = 1'b0;
        stall_inc       = 1'b0;
        flush_inc       = 1'b0;
        case (state)
            ST_BOOT: begin
                bus.if_id_flush = 1'b1;
                bus.id_ex_flush = 1'b1;
                state_nxt       = ST_RUN;
            end
            ST_RUN: begin
                if (bus.mem_access && !bus.dmem_ack) begin
                    bus.dmem_req = 1'b1;
                    wait_clr     = 1'b1;
                    stall_inc    = 1'b1;
                    state_nxt    = ST_MEM_WAIT;
                end else if (bus.mem_access) begin
                    bus.dmem_req = 1'b1;
                    en_all       = 1'b1;
                end else if (bus.ex_redirect) begin
                    en_all          = 1'b1;
                    bus.if_id_flush = 1'b1;
                    bus.id_ex_flush = 1'b1;
                    flush_inc       = 1'b1;
                end else if (load_use) begin
                    bus.id_ex_en    = 1'b1;
                    bus.ex_mem_en   = 1'b1;
                    bus.mem_wb_en   = 1'b1;
                    bus.id_ex_flush = 1'b1;
                    stall_inc       = 1'b1;
                end else begin
                    en_all = 1'b1;
                end
            end
            ST_MEM_WAIT: begin
                bus.dmem_req = 1'b1;
                if (bus.dmem_ack) begin
                    en_all    = 1'b1;
                    state_nxt = ST_RUN;
                    if (bus.ex_redirect) begin
                        bus.if_id_flush = 1'b1;
                        bus.id_ex_flush = 1'b1;
                        flush_inc       = 1'b1;
                    end
                end else begin
                    stall_inc = 1'b1;
                    if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1))
                        state_nxt = ST_HALT;
                    else
                        wait_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = ST_HALT;
            end
        endcase
        if (en_all) begin
            bus.pc_en     = 1'b1;
            bus.if_id_en  = 1'b1;
            bus.id_ex_en  = 1'b1;
            bus.ex_mem_en = 1'b1;
            bus.mem_wb_en = 1'b1;
        end
    end

    // State register and dmem wait timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_BOOT;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (wait_clr)
                wait_cnt <= '0;
            else if (wait_inc)
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (stall_inc),
        .cnt   (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .inc   (flush_inc),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer (4-bit counters to reach saturation).
module tb_pipeline_hazard_sequencer;

    logic       clk;
    logic       rst_n;
    logic       mem_fault;
    logic [3:0] stall_cnt;
    logic [3:0] flush_cnt;
    int         checks;
    int         errors;

    pipeline_hazard_sequencer_if pif ();

    pipeline_hazard_sequencer #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (pif),
        .mem_fault (mem_fault),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    logic [31:0] en_v, fl_v, st_v, fc_v;
    assign en_v = {27'd0, pif.pc_en, pif.if_id_en, pif.id_ex_en, pif.ex_mem_en, pif.mem_wb_en};
    assign fl_v = {30'd0, pif.if_id_flush, pif.id_ex_flush};
    assign st_v = {28'd0, stall_cnt};
    assign fc_v = {28'd0, flush_cnt};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        pif.id_rs1      = 5'd0;
        pif.id_rs2      = 5'd0;
        pif.id_uses_rs1 = 1'b0;
        pif.id_uses_rs2 = 1'b0;
        pif.ex_is_load  = 1'b0;
        pif.ex_rd       = 5'd0;
        pif.ex_redirect = 1'b0;
        pif.mem_access  = 1'b0;
        pif.dmem_ack    = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        repeat (2) step();
        #3;
        chk("rst_en", en_v, 'b00000);
        chk("rst_fl", fl_v, 'b11);
        chk("rst_req", {31'd0, pif.dmem_req}, 0);
        chk("rst_fault", {31'd0, mem_fault}, 0);
        chk("rst_stall", st_v, 0);
        chk("rst_flush", fc_v, 0);

        // Reset release: one BOOT cycle, then RUN.
        step();
        rst_n = 1'b1;
        #3;
        chk("boot_en", en_v, 'b00000);
        chk("boot_fl", fl_v, 'b11);
        step();
        #3;
        chk("run_en", en_v, 'b11111);
        chk("run_fl", fl_v, 'b00);

        // Load-use via rs2.
        step();
        pif.ex_is_load = 1'b1; pif.ex_rd = 5'd5; pif.id_rs2 = 5'd5; pif.id_uses_rs2 = 1'b1;
        #3;
        chk("lu2_en", en_v, 'b00111);
        chk("lu2_fl", fl_v, 'b01);
        step();
        clear_inputs();
        #3;
        chk("lu2_after_en", en_v, 'b11111);
        chk("lu2_stall", st_v, 1);

        // Load to x0 never stalls.
        pif.ex_is_load = 1'b1; pif.ex_rd = 5'd0; pif.id_rs2 = 5'd0; pif.id_uses_rs2 = 1'b1;
        #3;
        chk("x0_en", en_v, 'b11111);
        chk("x0_fl", fl_v, 'b00);
        step();
        clear_inputs();

        // Load-use via rs1, and the same match with rs1 unused.
        pif.ex_is_load = 1'b1; pif.ex_rd = 5'd7; pif.id_rs1 = 5'd7; pif.id_uses_rs1 = 1'b1;
        #3;
        chk("lu1_en", en_v, 'b00111);
        step();
        pif.id_uses_rs1 = 1'b0;
        #3;
        chk("lu1_unused_en", en_v, 'b11111);
        step();
        clear_inputs();
        #3;
        chk("lu1_stall", st_v, 2);

        // Redirect.
        pif.ex_redirect = 1'b1;
        #3;
        chk("redir_en", en_v, 'b11111);
        chk("redir_fl", fl_v, 'b11);
        step();
        clear_inputs();
        #3;
        chk("redir_cnt", fc_v, 1);
        chk("redir_after_fl", fl_v, 'b00);

        // Memory wait: ack low for 3 cycles, then high.
        pif.mem_access = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("mw_req", {31'd0, pif.dmem_req}, 1);
            chk("mw_en", en_v, 'b00000);
            step();
        end
        pif.dmem_ack = 1'b1;
        #3;
        chk("mw_ack_req", {31'd0, pif.dmem_req}, 1);
        chk("mw_ack_en", en_v, 'b11111);
        step();
        clear_inputs();
        #3;
        chk("mw_done_req", {31'd0, pif.dmem_req}, 0);
        chk("mw_stall", st_v, 5);

        // Zero-wait access.
        pif.mem_access = 1'b1; pif.dmem_ack = 1'b1;
        #3;
        chk("zw_req", {31'd0, pif.dmem_req}, 1);
        chk("zw_en", en_v, 'b11111);
        step();
        clear_inputs();
        #3;
        chk("zw_stall", st_v, 5);

        // Redirect pending when the memory ack arrives.
        pif.mem_access = 1'b1;
        step();
        pif.dmem_ack = 1'b1; pif.ex_redirect = 1'b1;
        #3;
        chk("mwr_en", en_v, 'b11111);
        chk("mwr_fl", fl_v, 'b11);
        step();
        clear_inputs();
        #3;
        chk("mwr_flush", fc_v, 2);
        chk("mwr_stall", st_v, 6);

        // Saturation: 20 load-use stalls.
        for (int i = 0; i < 20; i++) begin
            pif.ex_is_load = 1'b1; pif.ex_rd = 5'd3; pif.id_rs1 = 5'd3; pif.id_uses_rs1 = 1'b1;
            step();
            clear_inputs();
            step();
        end
        #3;
        chk("sat_stall", st_v, 15);

        // Timeout: 1 entry cycle + 15 waiting cycles, then HALT.
        pif.mem_access = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            #3;
            chk("to_wait", {30'd0, pif.dmem_req, mem_fault}, 'b10);
            step();
        end
        #3;
        chk("to_fault", {31'd0, mem_fault}, 1);
        chk("to_req", {31'd0, pif.dmem_req}, 0);
        chk("to_en", en_v, 'b00000);
        pif.dmem_ack = 1'b1;
        repeat (3) step();
        #3;
        chk("halt_sticky", {31'd0, mem_fault}, 1);
        chk("halt_en", en_v, 'b00000);
        chk("halt_stall", st_v, 15);

        // Reset releases HALT; reset mid-MEM_WAIT drops dmem_req at once.
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk("rst_fault_clr", {31'd0, mem_fault}, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        pif.mem_access = 1'b1;
        step();
        #3;
        chk("mw2_req", {31'd0, pif.dmem_req}, 1);
        rst_n = 1'b0;
        #1;
        chk("async_req", {31'd0, pif.dmem_req}, 0);
        chk("async_fl", fl_v, 'b11);
        chk("async_stall", st_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_sequencer.md
Name: pipeline_hazard_sequencer

Overview:
- Sequences the 5-stage RV32 subset pipeline (IF/ID/EX/MEM/WB) around the decoder's per-instruction flags.
- Issues per-register enable and flush strobes, and stalls on load-use hazards.
- Flushes wrong-path instructions on taken beq/jal.
- Holds the pipeline while the data memory handshake (lw/sw) completes.
- Sits beside the decoder in stage 2; pipeline registers and PC register obey its outputs.

Parameters:
- MEM_TIMEOUT, 15: maximum cycles waiting for dmem_ack before fault.
- CNT_W, 16: width of the stall/flush performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1  in  5  rs1 field of instruction in ID
- id_rs2  in  5  rs2 field of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_is_load  in  1  EX holds lw (registered lwOK)
- ex_rd  in  5  destination register of EX instruction
- ex_redirect  in  1  EX resolved jal or taken beq (registered branch)
- mem_access  in  1  MEM holds lw or sw
- dmem_ack  in  1  data memory completes access this cycle
- dmem_req  out  1  data memory request, held until ack
- pc_en  out  1  PC register load enable
- if_id_en  out  1  IF/ID register enable
- if_id_flush  out  1  IF/ID register clears to bubble
- id_ex_en  out  1  ID/EX register enable
- id_ex_flush  out  1  ID/EX register clears to bubble
- ex_mem_en  out  1  EX/MEM register enable
- mem_wb_en  out  1  MEM/WB register enable
- mem_fault  out  1  sticky: memory timeout occurred
- stall_cnt  out  CNT_W  cycles lost to load-use and memory stalls (saturating)
- flush_cnt  out  CNT_W  number of redirects (saturating)

Behaviour:
- States: BOOT, RUN, MEM_WAIT, HALT. Reset (async, rst_n=0) -> BOOT.
- Reset values: all enables 0, flushes 1, dmem_req 0, mem_fault 0, counters 0.
- BOOT: one cycle after rst_n rises; flushes held 1, enables 0; then go to RUN.
- RUN, priority high to low:
  1. mem_access=1 and dmem_ack=0: enter MEM_WAIT next cycle. This cycle: dmem_req=1, all enables 0, wait counter cleared.
  2. mem_access=1 and dmem_ack=1: zero-wait access, treated as normal advance; dmem_req=1 this cycle.
  3. ex_redirect=1: all enables 1, if_id_flush=1, id_ex_flush=1 (two bubbles), flush_cnt+1.
  4. Load-use hazard: ex_is_load=1, ex_rd!=0, and (id_uses_rs1 & id_rs1==ex_rd or id_uses_rs2 & id_rs2==ex_rd). Then pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1; stall_cnt+1. The hazard clears the next cycle because the load has moved on (exactly 1-cycle stall).
  5. Otherwise all enables 1, flushes 0.
- ex_redirect and ex_is_load are mutually exclusive (same stage); the bench must not drive both.
- MEM_WAIT: dmem_req=1, all enables 0, flushes 0, stall_cnt+1 per cycle, wait counter+1.
  - dmem_ack=1 -> RUN; all enables 1 that cycle. The MEM instruction retires. ex_redirect, if pending, is applied in this same cycle with rule 3 outputs.
  - Wait counter reaching MEM_TIMEOUT without ack -> HALT, mem_fault=1.
- HALT: all enables 0, dmem_req 0, mem_fault 1; exit only by reset.
- Counters saturate at all-ones and do not wrap.
- Outputs are combinational from state + inputs; state and counters are registered.
- Reset asserted mid-MEM_WAIT: dmem_req drops immediately (async).

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state encoding: BOOT=2'b00, RUN=2'b01, MEM_WAIT=2'b10, HALT=2'b11
  - REG_X0 = 5'd0
- One sub-module: sat_counter (parameterised width, inc, clear, async active-low reset), instantiated twice for stall_cnt and flush_cnt.

Test Plan:
- Reset release: rst_n 0->1 -> one BOOT cycle with flushes=1, enables=0; next cycle all enables=1, flushes=0.
- Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_uses_rs2=1 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1. Same with ex_rd=0 -> no stall.
- Redirect: ex_redirect=1 for one cycle -> if_id_flush=id_ex_flush=1, pc_en=1; flush_cnt=1.
- Memory wait: mem_access=1, dmem_ack low 3 cycles then high -> dmem_req=1 for 4 cycles, enables 0 for 3 cycles then 1; stall_cnt=3.
- Timeout: mem_access=1, dmem_ack never -> HALT after MEM_TIMEOUT cycles, mem_fault=1 sticky; enables stay 0 until rst_n=0.
- Saturation with CNT_W=4: 20 load-use stalls -> stall_cnt=15.
